// File: rtl/rc_c2f_buffer.sv
// rc_c2f_buffer
//   Core-to-fabric request buffer for the ring controller. Core requests that
//   miss local memory are parked in C2F_ENTRIESNUM entries, offered oldest-first
//   to the ring output arbiter, and tracked until the ring returns read data or
//   the broadcast loop-back. Read data goes back to the core tagged by entry.
//
// Ports
//   QClk, RstQnnnH                     clock, synchronous active-high reset
//   CoreReq{Valid,Opcode,Address,Data} request from core; CoreReqReady out
//   RingReq{Valid,Opcode,Address,Data,Tag} offered entry; RingReqGrant in
//   RingRsp{Valid,Opcode,Tag,Data}     ring message returned to this core
//   CoreRsp{Valid,Tag,Data}            read data to core; CoreRspReady in
//   C2fError                           sticky protocol error flag
//
// Entry states
//   state             | meaning
//   FREE              | unallocated, may be allocated
//   WRITE             | write waiting for grant
//   READ              | read waiting for grant
//   READ_PRGRS        | read on the ring, waiting for RD_RSP
//   READ_RDY          | read data held, waiting for core to take it
//   WRITE_BCAST       | broadcast write waiting for grant
//   WRITE_BCAST_PRGRS | broadcast on the ring, waiting for loop-back
//   ERROR             | protocol violation seen; sticky until reset
module rc_c2f_buffer #(
    parameter int C2F_ENTRIESNUM = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TAG_W          = $clog2(C2F_ENTRIESNUM)
) (
    input  logic              QClk,
    input  logic              RstQnnnH,
    input  logic              CoreReqValid,
    input  logic [1:0]        CoreReqOpcode,
    input  logic [ADDR_W-1:0] CoreReqAddress,
    input  logic [DATA_W-1:0] CoreReqData,
    output logic              CoreReqReady,
    output logic              RingReqValid,
    output logic [1:0]        RingReqOpcode,
    output logic [ADDR_W-1:0] RingReqAddress,
    output logic [DATA_W-1:0] RingReqData,
    output logic [TAG_W-1:0]  RingReqTag,
    input  logic              RingReqGrant,
    input  logic              RingRspValid,
    input  logic [1:0]        RingRspOpcode,
    input  logic [TAG_W-1:0]  RingRspTag,
    input  logic [DATA_W-1:0] RingRspData,
    output logic              CoreRspValid,
    output logic [TAG_W-1:0]  CoreRspTag,
    output logic [DATA_W-1:0] CoreRspData,
    input  logic              CoreRspReady,
    output logic              C2fError
);

    localparam int N = C2F_ENTRIESNUM;

    typedef enum logic [1:0] {
        RD       = 2'd0,
        WR       = 2'd1,
        WR_BCAST = 2'd2,
        RD_RSP   = 2'd3
    } t_opcode;

    typedef enum logic [2:0] {
        FREE              = 3'd0,
        WRITE             = 3'd1,
        READ              = 3'd2,
        READ_PRGRS        = 3'd3,
        READ_RDY          = 3'd4,
        WRITE_BCAST       = 3'd5,
        WRITE_BCAST_PRGRS = 3'd6,
        ERROR             = 3'd7
    } t_state;

    t_state            state_q [N];
    logic [1:0]        op_q    [N];
    logic [ADDR_W-1:0] addr_q  [N];
    logic [DATA_W-1:0] data_q  [N];
    // Number of still-pending entries allocated after this one. Only the
    // oldest pending entry is ever granted, so this never exceeds N-1 and
    // pending entries always hold distinct values.
    logic [TAG_W-1:0]  age_q   [N];
    logic              err_q;

    // Core response lock: once a response is shown without being taken,
    // keep showing the same entry even if a lower index becomes ready.
    logic              lock_q;
    logic [TAG_W-1:0]  lock_tag_q;

    logic              free_found;
    logic [TAG_W-1:0]  alloc_idx;
    logic              iss_found;
    logic [TAG_W-1:0]  iss_idx;
    logic [TAG_W-1:0]  iss_age;
    logic              rdy_found;
    logic [TAG_W-1:0]  rdy_idx;
    logic [TAG_W-1:0]  rsp_tag;
    logic              accept;
    logic              grant;
    logic              core_hs;
    logic              ring_err;
    logic              ring_ok_rd;
    logic              ring_ok_wb;

    always_comb begin
        free_found = 1'b0;
        alloc_idx  = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        iss_age    = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q[i] == FREE && !free_found) begin
                free_found = 1'b1;
                alloc_idx  = TAG_W'(i);
            end
            if ((state_q[i] == WRITE || state_q[i] == READ || state_q[i] == WRITE_BCAST)
                && (!iss_found || age_q[i] > iss_age)) begin
                iss_found = 1'b1;
                iss_idx   = TAG_W'(i);
                iss_age   = age_q[i];
            end
            if (state_q[i] == READ_RDY && !rdy_found) begin
                rdy_found = 1'b1;
                rdy_idx   = TAG_W'(i);
            end
        end
    end

    assign rsp_tag    = (lock_q && state_q[lock_tag_q] == READ_RDY) ? lock_tag_q : rdy_idx;

    assign accept     = CoreReqValid & free_found;
    assign grant      = RingReqGrant & iss_found;
    assign core_hs    = rdy_found & CoreRspReady;

    assign ring_ok_rd = (RingRspOpcode == RD_RSP)   && (state_q[RingRspTag] == READ_PRGRS);
    assign ring_ok_wb = (RingRspOpcode == WR_BCAST) && (state_q[RingRspTag] == WRITE_BCAST_PRGRS);
    assign ring_err   = RingRspValid && !(ring_ok_rd || ring_ok_wb);

    assign CoreReqReady   = free_found;
    assign RingReqValid   = iss_found;
    assign RingReqOpcode  = iss_found ? op_q[iss_idx]   : 2'd0;
    assign RingReqAddress = iss_found ? addr_q[iss_idx] : '0;
    assign RingReqData    = iss_found ? data_q[iss_idx] : '0;
    assign RingReqTag     = iss_found ? iss_idx         : '0;
    assign CoreRspValid   = rdy_found;
    assign CoreRspTag     = rdy_found ? rsp_tag         : '0;
    assign CoreRspData    = rdy_found ? data_q[rsp_tag] : '0;
    assign C2fError       = err_q;

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= FREE;
                op_q[i]    <= 2'd0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                age_q[i]   <= '0;
            end
            err_q      <= 1'b0;
            lock_q     <= 1'b0;
            lock_tag_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept && alloc_idx == TAG_W'(i)) begin
                    op_q[i]   <= CoreReqOpcode;
                    addr_q[i] <= CoreReqAddress;
                    data_q[i] <= CoreReqData;
                    age_q[i]  <= '0;
                    case (CoreReqOpcode)
                        RD:       state_q[i] <= READ;
                        WR:       state_q[i] <= WRITE;
                        WR_BCAST: state_q[i] <= WRITE_BCAST;
                        default:  state_q[i] <= ERROR;
                    endcase
                end else if (accept && (state_q[i] == WRITE || state_q[i] == READ
                                        || state_q[i] == WRITE_BCAST)) begin
                    age_q[i] <= age_q[i] + TAG_W'(1);
                end

                if (grant && iss_idx == TAG_W'(i)) begin
                    case (state_q[i])
                        WRITE:       state_q[i] <= FREE;
                        READ:        state_q[i] <= READ_PRGRS;
                        WRITE_BCAST: state_q[i] <= WRITE_BCAST_PRGRS;
                        default:     state_q[i] <= state_q[i];
                    endcase
                end

                if (core_hs && rsp_tag == TAG_W'(i)) begin
                    state_q[i] <= FREE;
                end

                // Ring response is last so an error on an entry that is
                // simultaneously granted or consumed wins.
                if (RingRspValid && RingRspTag == TAG_W'(i)) begin
                    if (ring_ok_rd) begin
                        state_q[i] <= READ_RDY;
                        data_q[i]  <= RingRspData;
                    end else if (ring_ok_wb) begin
                        state_q[i] <= FREE;
                    end else begin
                        state_q[i] <= ERROR;
                    end
                end
            end

            err_q <= err_q | ring_err | (accept && CoreReqOpcode == RD_RSP);

            if (core_hs) begin
                lock_q <= 1'b0;
            end else if (rdy_found) begin
                lock_q     <= 1'b1;
                lock_tag_q <= rsp_tag;
            end else begin
                lock_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rc_c2f_buffer.sv
module tb_rc_c2f_buffer;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, WB = 2'd2, RR = 2'd3;

    logic        QClk = 1'b0;
    logic        RstQnnnH;
    logic        CoreReqValid;
    logic [1:0]  CoreReqOpcode;
    logic [31:0] CoreReqAddress;
    logic [31:0] CoreReqData;
    logic        CoreReqReady;
    logic        RingReqValid;
    logic [1:0]  RingReqOpcode;
    logic [31:0] RingReqAddress;
    logic [31:0] RingReqData;
    logic [1:0]  RingReqTag;
    logic        RingReqGrant;
    logic        RingRspValid;
    logic [1:0]  RingRspOpcode;
    logic [1:0]  RingRspTag;
    logic [31:0] RingRspData;
    logic        CoreRspValid;
    logic [1:0]  CoreRspTag;
    logic [31:0] CoreRspData;
    logic        CoreRspReady;
    logic        C2fError;

    always #5 QClk = ~QClk;

    rc_c2f_buffer dut (
        .QClk(QClk), .RstQnnnH(RstQnnnH),
        .CoreReqValid(CoreReqValid), .CoreReqOpcode(CoreReqOpcode),
        .CoreReqAddress(CoreReqAddress), .CoreReqData(CoreReqData),
        .CoreReqReady(CoreReqReady),
        .RingReqValid(RingReqValid), .RingReqOpcode(RingReqOpcode),
        .RingReqAddress(RingReqAddress), .RingReqData(RingReqData),
        .RingReqTag(RingReqTag), .RingReqGrant(RingReqGrant),
        .RingRspValid(RingRspValid), .RingRspOpcode(RingRspOpcode),
        .RingRspTag(RingRspTag), .RingRspData(RingRspData),
        .CoreRspValid(CoreRspValid), .CoreRspTag(CoreRspTag),
        .CoreRspData(CoreRspData), .CoreRspReady(CoreRspReady),
        .C2fError(C2fError)
    );

    typedef struct {
        logic        rst;
        logic        rv;   logic [1:0] rop; logic [31:0] ra; logic [31:0] rd;
        logic        gnt;
        logic        sv;   logic [1:0] sop; logic [1:0]  stag; logic [31:0] sd;
        logic        crdy;
        logic        e_rdy;
        logic        e_rv; logic [1:0] e_op; logic [31:0] e_a; logic [31:0] e_d; logic [1:0] e_tag;
        logic        e_cv; logic [1:0] e_ct; logic [31:0] e_cd;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(
        input logic rst, input logic rv, input logic [1:0] rop, input logic [31:0] ra,
        input logic [31:0] rd, input logic gnt, input logic sv, input logic [1:0] sop,
        input logic [1:0] stag, input logic [31:0] sd, input logic crdy,
        input logic e_rdy, input logic e_rv, input logic [1:0] e_op, input logic [31:0] e_a,
        input logic [31:0] e_d, input logic [1:0] e_tag, input logic e_cv,
        input logic [1:0] e_ct, input logic [31:0] e_cd, input logic e_err);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rop = rop; v.ra = ra; v.rd = rd; v.gnt = gnt;
        v.sv = sv; v.sop = sop; v.stag = stag; v.sd = sd; v.crdy = crdy;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_op = e_op; v.e_a = e_a; v.e_d = e_d;
        v.e_tag = e_tag; v.e_cv = e_cv; v.e_ct = e_ct; v.e_cd = e_cd; v.e_err = e_err;
        vecs.push_back(v);
    endfunction

    // Drives one cycle of inputs (called just after a rising edge), checks the
    // registered-state outputs at the falling edge, then advances past the next edge.
    task automatic run_vec(input vec_t v, input string name);
        logic bad;
        RstQnnnH       = v.rst;
        CoreReqValid   = v.rv;  CoreReqOpcode = v.rop;
        CoreReqAddress = v.ra;  CoreReqData   = v.rd;
        RingReqGrant   = v.gnt;
        RingRspValid   = v.sv;  RingRspOpcode = v.sop;
        RingRspTag     = v.stag; RingRspData  = v.sd;
        CoreRspReady   = v.crdy;
        @(negedge QClk);
        n_vec++;
        bad = (CoreReqReady !== v.e_rdy) || (RingReqValid !== v.e_rv) ||
              (RingReqOpcode !== v.e_op) || (RingReqAddress !== v.e_a) ||
              (RingReqData !== v.e_d) || (RingReqTag !== v.e_tag) ||
              (CoreRspValid !== v.e_cv) || (CoreRspTag !== v.e_ct) ||
              (CoreRspData !== v.e_cd) || (C2fError !== v.e_err);
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b rv=%b op=%0d a=%h d=%h tag=%0d cv=%b ct=%0d cd=%h err=%b, required rdy=%b rv=%b op=%0d a=%h d=%h tag=%0d cv=%b ct=%0d cd=%h err=%b",
                     name, CoreReqReady, RingReqValid, RingReqOpcode, RingReqAddress, RingReqData,
                     RingReqTag, CoreRspValid, CoreRspTag, CoreRspData, C2fError,
                     v.e_rdy, v.e_rv, v.e_op, v.e_a, v.e_d, v.e_tag, v.e_cv, v.e_ct, v.e_cd, v.e_err);
        end
        @(posedge QClk);
        #1;
    endtask

    // Runs whatever has been queued so far, then empties the queue.
    task automatic run_queue(input string name);
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("%s[%0d]", name, i));
        vecs.delete();
    endtask

    initial begin
        RstQnnnH = 1'b1;
        CoreReqValid = 1'b0; CoreReqOpcode = RD; CoreReqAddress = '0; CoreReqData = '0;
        RingReqGrant = 1'b0; RingRspValid = 1'b0; RingRspOpcode = RD; RingRspTag = '0;
        RingRspData = '0; CoreRspReady = 1'b0;
        repeat (2) @(posedge QClk);
        #1;

        //  rst rv op ra           rd           g  sv sop stg sd           cr | rdy rv op ea           ed           tg cv ct cd           err
        // single write
        add(0, 1,WR,32'h0240_0010,32'hDEAD_BEEF,0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h0240_0010,32'hDEAD_BEEF,0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // single read round trip
        add(0, 1,RD,32'h0300_0004,32'h0,      0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,RD,32'h0300_0004,32'h0,      0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 0,32'h1234_5678,0,  1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       1,   1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'h1234_5678,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // fill all four entries, refuse a fifth, drain in age order
        add(0, 1,RD,32'h100,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,RD,32'h104,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 1,RD,32'h100,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,RD,32'h108,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 1,RD,32'h100,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,RD,32'h10C,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 1,RD,32'h100,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,RD,32'h200,     32'h0,       0, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h100,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h100,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h104,     32'h0,       1, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h108,     32'h0,       2, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h10C,     32'h0,       3, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 2,32'hAAAA_0002,0,  0, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   0, 0,0, 32'h0,       32'h0,       0, 1,2, 32'hAAAA_0002,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       1,   0, 0,0, 32'h0,       32'h0,       0, 1,2, 32'hAAAA_0002,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 0,32'hB000_0000,0,  1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 1,32'hB000_0001,1,  1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'hB000_0000,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 3,32'hB000_0003,1,  1, 0,0, 32'h0,       32'h0,       0, 1,1, 32'hB000_0001,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       1,   1, 0,0, 32'h0,       32'h0,       0, 1,3, 32'hB000_0003,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // broadcast write with loop-back
        add(0, 1,WB,32'hFF40_0000,32'hCAFE_0000,0,0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WB,32'hFF40_0000,32'hCAFE_0000,0,0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,WB, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // response held for 5 cycles while a write is accepted and granted
        add(0, 1,RD,32'h400,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,RD,32'h400,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 0,32'h5A5A_5A5A,0,  1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,WR,32'h500,     32'h77,      0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'h5A5A_5A5A,0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h500,     32'h77,      1, 1,0, 32'h5A5A_5A5A,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'h5A5A_5A5A,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'h5A5A_5A5A,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'h5A5A_5A5A,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       1,   1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'h5A5A_5A5A,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // stray response poisons entry 3; only entries 0..2 are allocated afterwards
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 3,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,RD,32'h600,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       1);
        add(0, 1,RD,32'h604,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 1,RD,32'h600,     32'h0,       0, 0,0, 32'h0,       1);
        add(0, 1,RD,32'h608,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 1,RD,32'h600,     32'h0,       0, 0,0, 32'h0,       1);
        add(0, 1,RD,32'h60C,     32'h0,       0, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h600,     32'h0,       0, 0,0, 32'h0,       1);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h600,     32'h0,       0, 0,0, 32'h0,       1);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h604,     32'h0,       1, 0,0, 32'h0,       1);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   0, 1,RD,32'h608,     32'h0,       2, 0,0, 32'h0,       1);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   0, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       1);
        add(1, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   0, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       1);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // after reset all four entries allocate again
        add(0, 1,WR,32'h700,     32'h1,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,WR,32'h704,     32'h2,       0, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h700,     32'h1,       0, 0,0, 32'h0,       0);
        add(0, 1,WR,32'h708,     32'h3,       0, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h700,     32'h1,       0, 0,0, 32'h0,       0);
        add(0, 1,WR,32'h70C,     32'h4,       0, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h700,     32'h1,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   0, 1,WR,32'h700,     32'h1,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h704,     32'h2,       1, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h708,     32'h3,       2, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h70C,     32'h4,       3, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // age order beats index order: entry 1 is older than reused entry 0
        add(0, 1,WR,32'h800,     32'h8,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,WR,32'h804,     32'h9,       0, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h800,     32'h8,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h800,     32'h8,       0, 0,0, 32'h0,       0);
        add(0, 1,WR,32'h808,     32'hA,       0, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h804,     32'h9,       1, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h804,     32'h9,       1, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'h808,     32'hA,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // core request carrying RD_RSP is an error
        add(0, 1,RR,32'h900,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       1);
        add(1, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       1);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        run_queue("table");

        // Hand sequence: held response stays on entry 1 while entry 0 becomes ready.
        add(0, 1,RD,32'hA00,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 1,RD,32'hA04,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 1,RD,32'hA00,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,RD,32'hA00,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,RD,32'hA04,     32'h0,       1, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 1,32'h1111_1111,0,  1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 0,32'h2222_2222,0,  1, 0,0, 32'h0,       32'h0,       0, 1,1, 32'h1111_1111,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 1,1, 32'h1111_1111,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       1,   1, 0,0, 32'h0,       32'h0,       0, 1,1, 32'h1111_1111,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       1,   1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'h2222_2222,0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // Grant with nothing offered is ignored; same-cycle request shows up next cycle.
        add(0, 1,WR,32'hB00,     32'h5,       1, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,WR,32'hB00,     32'h5,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        // Read whose response latency is measured below.
        add(0, 1,RD,32'hC00,     32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 0,RD, 0,32'h0,       0,   1, 1,RD,32'hC00,     32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 1,RR, 0,32'h3333_3333,0,  1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        run_queue("hand");

        begin
            int lat;
            lat = 0;
            RingRspValid = 1'b0;
            CoreRspReady = 1'b0;
            @(negedge QClk);
            while (!CoreRspValid && lat < 8) begin
                @(posedge QClk); #1;
                @(negedge QClk);
                lat++;
            end
            n_vec++;
            if (CoreRspValid !== 1'b1 || lat != 0) begin
                n_bad++;
                $display("FAIL rsp_latency: got valid=%b after %0d extra cycles, required valid=1 after 0", CoreRspValid, lat);
            end
            @(posedge QClk); #1;
        end

        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       1,   1, 0,0, 32'h0,       32'h0,       0, 1,0, 32'h3333_3333,0);
        // Ring response on the entry granted in the same cycle is an error.
        add(0, 1,WR,32'hD00,     32'h6,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       1, 1,WB, 0,32'h0,       0,   1, 1,WR,32'hD00,     32'h6,       0, 0,0, 32'h0,       0);
        add(0, 0,RD,32'h0,       32'h0,       0, 0,RD, 0,32'h0,       0,   1, 0,0, 32'h0,       32'h0,       0, 0,0, 32'h0,       1);
        run_queue("hand2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rc_c2f_buffer.md
Name: rc_c2f_buffer

Overview:
- Core-to-fabric (C2F) request buffer for the ring controller.
- Accepts memory requests from the core that miss local memory and holds them in C2F_ENTRIESNUM entries.
- Presents one pending request per cycle to the ring output arbiter (winner C2F_REQUEST) and tracks each outstanding read or broadcast until the ring returns it.
- Returns read data to the core, tagged by entry index.

Parameters:
- C2F_ENTRIESNUM, 4, number of buffer entries; must be a power of 2 and at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TAG_W, $clog2(C2F_ENTRIESNUM), entry tag width (2 at default).

Ports:
- QClk  in  1  clock.
- RstQnnnH  in  1  synchronous active-high reset.
- CoreReqValid  in  1  core request present.
- CoreReqOpcode  in  2  t_opcode; RD, WR or WR_BCAST only.
- CoreReqAddress  in  ADDR_W  request address.
- CoreReqData  in  DATA_W  write data; ignored for RD.
- CoreReqReady  out  1  buffer can accept a request this cycle.
- RingReqValid  out  1  a pending entry is offered to the arbiter.
- RingReqOpcode  out  2  opcode of the offered entry.
- RingReqAddress  out  ADDR_W  address of the offered entry.
- RingReqData  out  DATA_W  data of the offered entry.
- RingReqTag  out  TAG_W  index of the offered entry.
- RingReqGrant  in  1  arbiter selected C2F_REQUEST this cycle.
- RingRspValid  in  1  ring message addressed back to this core.
- RingRspOpcode  in  2  RD_RSP or WR_BCAST (broadcast loop-back).
- RingRspTag  in  TAG_W  entry the message belongs to.
- RingRspData  in  DATA_W  read data.
- CoreRspValid  out  1  read data available to the core.
- CoreRspTag  out  TAG_W  entry index of the returned data.
- CoreRspData  out  DATA_W  returned read data.
- CoreRspReady  in  1  core accepts the response.
- C2fError  out  1  sticky protocol error flag.

Behaviour:
- Reset (synchronous, RstQnnnH=1 at a QClk edge):
  - All entries go to FREE; any in-flight operation is discarded.
  - All outputs are 0 except CoreReqReady, which is 1 once out of reset.
- Entry state is t_state, one register per entry. Transitions:
  - FREE -> WRITE, READ or WRITE_BCAST on acceptance, selected by CoreReqOpcode.
  - WRITE -> FREE on grant.
  - READ -> READ_PRGRS on grant.
  - READ_PRGRS -> READ_RDY on RingRspValid, RingRspOpcode=RD_RSP and a matching tag; RingRspData is captured.
  - READ_RDY -> FREE on CoreRspValid & CoreRspReady.
  - WRITE_BCAST -> WRITE_BCAST_PRGRS on grant.
  - WRITE_BCAST_PRGRS -> FREE on RingRspValid, RingRspOpcode=WR_BCAST and a matching tag.
- Protocol errors move the addressed entry to ERROR and set C2fError:
  - A response whose tag points to an entry not in the matching *_PRGRS state.
  - An opcode mismatch.
  - A core request with opcode RD_RSP.
  - ERROR and C2fError are sticky until reset. An entry in ERROR is never reallocated.
- Acceptance:
  - CoreReqReady = at least one entry is FREE, computed from registered state only.
  - The request is accepted when CoreReqValid & CoreReqReady.
  - The lowest-index FREE entry is allocated.
  - An entry freed in cycle N becomes allocatable in cycle N+1; there is no same-cycle reuse.
- Issue:
  - RingReqValid = any entry is in WRITE, READ or WRITE_BCAST.
  - The offered entry is the oldest pending one, by allocation order tracked with a per-entry age counter; ties cannot occur.
  - The offer is combinational from registers and stays stable until granted.
  - RingReqGrant while RingReqValid=0 is ignored.
  - An entry accepted in cycle N is first offered in cycle N+1.
- Read response to core:
  - CoreRspValid = any entry is in READ_RDY. The lowest-index READ_RDY entry is presented.
  - Tag and data hold stable while CoreRspValid & !CoreRspReady.
  - Latency from an RD_RSP at edge N to CoreRspValid is 1 cycle.
- Simultaneous events in one cycle are all legal and independent:
  - acceptance;
  - grant;
  - ring response;
  - core response.
  - Each touches a different entry by construction.
  - A ring response for the entry being granted that same cycle is a protocol error.
- Widths: tags are unsigned TAG_W. Address and data are passed through unmodified.

Test Plan:
- Reset, then a WR to addr 0x0240_0010 with data 0xDEADBEEF → offered next cycle with RingReqTag=0. Grant → entry 0 FREE; CoreReqReady stays 1.
- RD to 0x0300_0004, grant, then RD_RSP on tag 0 with data 0x12345678 → CoreRspValid 1 cycle later with data 0x12345678, tag 0. Entry is FREE after CoreRspReady.
- Issue 4 RDs with no grant → CoreReqReady=0 after the 4th. Grant one WR... grant all 4, return RD_RSP for tag 2 → CoreRspTag=2. CoreReqReady returns 1 the cycle after that response is consumed.
- WR_BCAST to 0xFF40_0000, grant → entry in WRITE_BCAST_PRGRS and CoreReqReady unaffected. Loop-back WR_BCAST on tag 0 → entry FREE; no CoreRspValid.
- RD_RSP on tag 3 while entry 3 is FREE → C2fError=1 and entry 3 in ERROR. After the other entries are used, only 3 are ever allocated. Reset clears the error.
- Read data returned with CoreRspReady=0 for 5 cycles → CoreRspTag and CoreRspData stable for all 5 cycles. A new request accepted and granted in the same window proceeds normally.
